// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM states and widths for decode_execute
package cpu_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int NREG_DEFAULT   = 4;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_LI     = 2'b01;
  localparam logic [1:0] OP_SUB    = 2'b10;
  localparam logic [1:0] OP_EXT    = 2'b11;
  localparam logic [7:0] INST_HALT = 8'hFF;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    EXEC   = 2'd1,
    WB     = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/alu8.sv
// rtl/alu8.sv - combinational ALU: add, pass-immediate, subtract with borrow, shift left
module alu8
  import cpu_pkg::*;
#(
  parameter int W = DATA_W_DEFAULT
) (
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result,
  output logic         o_carry,
  output logic         o_zero
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;
  logic [W:0] w_shl;

  // Bit W of each extended result is carry, borrow, or the last bit shifted out.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_shl  = {1'b0, i_a} << i_b[1:0];

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[W-1:0];
        o_carry  = w_sum[W];
      end
      OP_SUB: begin
        o_result = w_diff[W-1:0];
        o_carry  = w_diff[W];
      end
      OP_EXT: begin
        o_result = w_shl[W-1:0];
        o_carry  = w_shl[W];
      end
      default: begin
        o_result = i_b;
        o_carry  = 1'b0;
      end
    endcase
    o_zero = (o_result == '0);
  end

endmodule

// File: rtl/decode_execute.sv
// rtl/decode_execute.sv - serial accept/execute/writeback stage with 4-entry register file
module decode_execute
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int NREG   = NREG_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inst_valid,
  input  logic [7:0]        i_inst,
  output logic              o_inst_ready,
  output logic              o_wb_en,
  output logic [1:0]        o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  output logic              o_zero_flag,
  output logic              o_carry_flag,
  output logic              o_halted,
  output logic [7:0]        o_retired,
  input  logic [1:0]        i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_inst;
  logic [DATA_W-1:0] r_result;
  logic [1:0]        r_rd;
  logic              r_zero;
  logic              r_carry;
  logic [7:0]        r_retired;
  logic [DATA_W-1:0] r_regs [NREG];

  logic [1:0]        w_op;
  logic              w_is_halt;
  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic              w_alu_zero;

  assign w_op      = r_inst[7:6];
  assign w_is_halt = (r_inst == INST_HALT);
  assign w_alu_a   = r_regs[r_inst[3:2]];

  // Operand b is the rt register, the zero-extended immediate for LI, or the shift amount for SHL.
  always_comb begin
    w_alu_b = r_regs[r_inst[1:0]];
    case (w_op)
      OP_LI:   w_alu_b = {{(DATA_W-4){1'b0}}, r_inst[3:0]};
      OP_EXT:  w_alu_b = {{(DATA_W-2){1'b0}}, r_inst[1:0]};
      default: w_alu_b = r_regs[r_inst[1:0]];
    endcase
  end

  alu8 #(.W(DATA_W)) u_alu (
    .i_op     (w_op),
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry),
    .o_zero   (w_alu_zero)
  );

  always_comb begin
    w_next_state = r_state;
    o_inst_ready = 1'b0;
    o_wb_en      = 1'b0;
    case (r_state)
      ACCEPT: begin
        o_inst_ready = 1'b1;
        if (i_inst_valid) w_next_state = EXEC;
      end
      EXEC:    w_next_state = w_is_halt ? HALTED : WB;
      WB: begin
        o_wb_en      = 1'b1;
        w_next_state = ACCEPT;
      end
      default: w_next_state = HALTED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ACCEPT;
      r_inst    <= '0;
      r_result  <= '0;
      r_rd      <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_retired <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ACCEPT: if (i_inst_valid) r_inst <= i_inst;
        EXEC: begin
          if (w_is_halt) begin
            r_retired <= r_retired + 8'd1;
          end else begin
            r_result <= w_alu_result;
            r_rd     <= r_inst[5:4];
            if (w_op != OP_LI) begin
              r_zero  <= w_alu_zero;
              r_carry <= w_alu_carry;
            end
          end
        end
        WB: begin
          r_regs[r_rd] <= r_result;
          r_retired    <= r_retired + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_wb_addr    = r_rd;
  assign o_wb_data    = r_result;
  assign o_zero_flag  = r_zero;
  assign o_carry_flag = r_carry;
  assign o_halted     = (r_state == HALTED);
  assign o_retired    = r_retired;
  assign o_dbg_data   = r_regs[i_dbg_addr];

endmodule

// File: tb/tb_decode_execute.sv
// tb/tb_decode_execute.sv - directed self-checking bench for decode_execute
module tb_decode_execute;

  logic       clk = 1'b0;
  logic       rst;
  logic       inst_valid;
  logic [7:0] inst;
  logic       inst_ready;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       zero_flag;
  logic       carry_flag;
  logic       halted;
  logic [7:0] retired;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  decode_execute dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_inst_valid (inst_valid),
    .i_inst       (inst),
    .o_inst_ready (inst_ready),
    .o_wb_en      (wb_en),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_data),
    .o_zero_flag  (zero_flag),
    .o_carry_flag (carry_flag),
    .o_halted     (halted),
    .o_retired    (retired),
    .i_dbg_addr   (dbg_addr),
    .o_dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    inst_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Called at a negedge while in ACCEPT; returns at the negedge after writeback.
  task automatic issue(input string tag, input logic [7:0] ins,
                       input logic [1:0] exp_addr, input logic [7:0] exp_data);
    inst       = ins;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    check({tag, ":exec_ready"}, inst_ready, 0);
    check({tag, ":exec_wb_en"}, wb_en, 0);
    @(negedge clk);
    check({tag, ":wb_en"}, wb_en, 1);
    check({tag, ":wb_addr"}, wb_addr, exp_addr);
    check({tag, ":wb_data"}, wb_data, exp_data);
    @(negedge clk);
    check({tag, ":post_ready"}, inst_ready, 1);
    check({tag, ":post_wb_en"}, wb_en, 0);
  endtask

  logic [7:0] stream [4];
  logic       exp_rdy;
  logic       exp_wb;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst       = 8'h00;
    dbg_addr   = 2'd0;
    do_reset();

    check("rst:ready", inst_ready, 1);
    check("rst:wb_en", wb_en, 0);
    check("rst:wb_addr", wb_addr, 0);
    check("rst:wb_data", wb_data, 0);
    check("rst:zero", zero_flag, 0);
    check("rst:carry", carry_flag, 0);
    check("rst:halted", halted, 0);
    check("rst:retired", retired, 0);
    for (int i = 0; i < 4; i++) reg_chk("rst:reg", i[1:0], 8'h00);

    issue("li_r1_5", 8'h55, 2'd1, 8'h05);
    reg_chk("r1_is_5", 2'd1, 8'h05);
    check("retired_1", retired, 1);

    issue("li_r1_15", 8'h5F, 2'd1, 8'h0F);
    issue("li_r2_1", 8'h61, 2'd2, 8'h01);
    issue("add_r3", 8'h36, 2'd3, 8'h10);
    check("add:carry", carry_flag, 0);
    check("add:zero", zero_flag, 0);
    reg_chk("r3_is_10", 2'd3, 8'h10);
    issue("li_r0_15", 8'h4F, 2'd0, 8'h0F);
    issue("shl_r0_3", 8'hC3, 2'd0, 8'h78);
    check("shl:carry", carry_flag, 0);
    check("shl:zero", zero_flag, 0);

    issue("sub_r2_self", 8'hAA, 2'd2, 8'h00);
    check("sub0:zero", zero_flag, 1);
    check("sub0:carry", carry_flag, 0);
    issue("li_r1_0", 8'h50, 2'd1, 8'h00);
    check("li:zero_kept", zero_flag, 1);
    issue("li_r2_1b", 8'h61, 2'd2, 8'h01);
    issue("sub_borrow", 8'hB6, 2'd3, 8'hFF);
    check("borrow:carry", carry_flag, 1);
    check("borrow:zero", zero_flag, 0);
    issue("li_r1_0b", 8'h50, 2'd1, 8'h00);
    check("li:carry_kept", carry_flag, 1);

    issue("shl_out", 8'hCD, 2'd0, 8'hFE);
    check("shl_out:carry", carry_flag, 1);
    issue("add_ovf", 8'h1F, 2'd1, 8'hFE);
    check("add_ovf:carry", carry_flag, 1);
    issue("li_r2_1c", 8'h61, 2'd2, 8'h01);
    issue("add_wrap0", 8'h1E, 2'd1, 8'h00);
    check("wrap0:carry", carry_flag, 1);
    check("wrap0:zero", zero_flag, 1);
    reg_chk("r1_wrap0", 2'd1, 8'h00);
    reg_chk("r0_fe", 2'd0, 8'hFE);
    check("retired_15", retired, 15);

    do_reset();
    inst       = 8'h55;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst:ready", inst_ready, 1);
    check("midrst:wb_en", wb_en, 0);
    check("midrst:retired", retired, 0);
    reg_chk("midrst:r1", 2'd1, 8'h00);

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("idle:ready", inst_ready, 1);
      check("idle:wb_en", wb_en, 0);
      check("idle:retired", retired, 0);
    end

    do_reset();
    stream[0] = 8'h00;
    stream[1] = 8'h55;
    stream[2] = 8'hAA;
    stream[3] = 8'hFF;
    inst_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      exp_rdy = (c % 3 == 0) && (c <= 9);
      exp_wb  = (c % 3 == 2) && (c < 9);
      if (c % 3 == 0 && c <= 9) inst = stream[c / 3];
      else inst = 8'h4F;
      check($sformatf("stream:ready_c%0d", c), inst_ready, exp_rdy);
      check($sformatf("stream:wb_en_c%0d", c), wb_en, exp_wb);
      @(negedge clk);
    end
    check("halt:halted", halted, 1);
    check("halt:retired", retired, 4);
    inst = 8'h55;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("halted:ready", inst_ready, 0);
      check("halted:wb_en", wb_en, 0);
      check("halted:sticky", halted, 1);
    end
    inst_valid = 1'b0;
    check("halted:retired", retired, 4);
    check("halted:zero", zero_flag, 1);
    reg_chk("stream:r1", 2'd1, 8'h05);
    reg_chk("stream:r0", 2'd0, 8'h00);

    do_reset();
    check("unhalt:halted", halted, 0);
    check("unhalt:ready", inst_ready, 1);
    check("unhalt:retired", retired, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_execute.md
Name: decode_execute

Overview:
Downstream stage of the instruction fetch memory. Accepts one 8-bit instruction per valid/ready handshake, then decodes and executes it against a 4 x 8-bit register file. Execution is a 3-state FSM (ACCEPT, EXEC, WB); register writeback and flags are exposed for debug and verification. The upstream fetch stage must hold inst and inst_valid stable while inst_ready is low.

Parameters:
DATA_W, 8, register and ALU data width
NREG, 4, number of general registers (index width 2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
inst_valid  in  1  upstream presents a valid instruction
inst  in  8  instruction word
inst_ready  out  1  stage can accept an instruction this cycle
wb_en  out  1  register write strobe (1 cycle)
wb_addr  out  2  destination register index
wb_data  out  DATA_W  value written
zero_flag  out  1  last ALU result == 0
carry_flag  out  1  carry/borrow of last ADD/SUB
halted  out  1  HALT executed; sticky until rst
retired  out  8  count of retired instructions, wraps 255->0
dbg_addr  in  2  debug register read index
dbg_data  out  DATA_W  combinational read of reg[dbg_addr]

Behaviour:
- Encoding, inst[7:6] = opcode:
  - 00 ADD rd=inst[5:4], rs=[3:2], rt=[1:0]: rd = rs+rt mod 256; carry = bit 8.
  - 01 LI rd=[5:4], imm=[3:0]: rd = {4'b0, imm}; flags unchanged.
  - 10 SUB rd, rs, rt (same fields): rd = rs-rt mod 256; carry = 1 when rs<rt (borrow).
  - 11 with inst == 8'hFF: HALT. Any other 11 encoding is SHL rd=[5:4], rs=[3:2], sh=[1:0]: rd = rs << sh, zero-fill; carry = last bit shifted out (0 when sh=0).
- FSM states and transitions:
  - ACCEPT: inst_ready=1. When inst_valid=1, latch inst into an internal register and go to EXEC; otherwise stay.
  - EXEC: inst_ready=0. Read operands and compute the result into a result register. Update zero/carry (zero for ADD/SUB/SHL only). HALT goes to HALTED; all others go to WB.
  - WB: wb_en=1 for exactly this cycle, reg[rd] <= result, retired += 1; next state is ACCEPT.
  - HALTED: inst_ready=0, halted=1, retired += 1 on entry only. Stays until rst.
- Throughput: 1 instruction per 3 cycles. An accept at edge N gives wb_en high in cycle N+2, with the register updated at the end of that cycle.
- Operand reads in EXEC see writes from any previous WB; there is no forwarding hazard because the FSM is serial.
- Writing rd == rs in the same instruction is legal and uses the old rs value.
- Reset (any state, including mid-EXEC/WB): state=ACCEPT, all regs=0, flags=0, retired=0, halted=0, wb_en=0, wb_addr=0, wb_data=0. An instruction in flight is discarded and not retired.
- wb_addr and wb_data hold their last values outside WB; only wb_en qualifies them.
- inst_valid low in ACCEPT means no state change.
- inst changing while not in ACCEPT is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_LI=2'b01, OP_SUB=2'b10, OP_EXT=2'b11, INST_HALT=8'hFF
  - state enum {ACCEPT, EXEC, WB, HALTED}
  - DATA_W default
- One natural sub-module: alu8, combinational, taking op, a, b/sh and producing result, carry, zero. The FSM and register file stay in decode_execute.

Test Plan:
- Reset, then present 8'h55 (LI r1,5) with valid held: accept at cycle 1, wb_en in cycle 3 with wb_addr=1, wb_data=8'h05; dbg r1=5; retired=1.
- LI r1,15 (8'h5F); LI r2,1 (8'h61); ADD r3,r1,r2 (8'h36) -> r3=8'h10, carry=0, zero=0. Then SHL r3,r3,3 (8'hFF is HALT, so use r0 instead): LI r0,15 (8'h4F), SHL r0,r0,3 (8'hC3) -> r0=8'h78, carry=0.
- SUB r2,r2,r2 (8'hAA) after r2=1 -> r2=0, zero=1, carry=0; then LI r1,0 (8'h50), LI r2,1, SUB r3,r1,r2 (8'hB6) -> r3=8'hFF, carry=1.
- Stream 00,55,AA,FF with valid always high -> inst_ready pattern 1,0,0 repeating; HALT reached after 3 WBs; halted=1, retired=4; further inst_valid ignored for 20 cycles.
- Assert rst during EXEC of LI r1,5 -> no wb_en, r1 stays 0, retired=0, inst_ready=1 in the next cycle.
- inst_valid low for 5 cycles in ACCEPT -> no state change, wb_en stays 0.
